// File: rtl/pool_window_buffer.sv
// Builds non-overlapping 2x2 pooling windows from a raster pixel stream and handshakes with the pooler.
// Optional build macro PWB_RELU_EN: negative pixels are clamped to zero on ingest.
module pool_window_buffer #(
    parameter int IL    = 8,
    parameter int FL    = 12,
    parameter int MAP_W = 8,
    parameter int MAP_H = 8,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IL+FL-1:0] in_data,
    output logic             in_ready,
    output logic [IL+FL-1:0] win [SIZE-1:0],
    output logic             win_en,
    output logic             win_start,
    input  logic             pool_done,
    output logic             pool_valid,
    output logic             frame_done
);

    localparam int DW    = IL + FL;
    localparam int COL_W = $clog2(MAP_W);
    localparam int ROW_W = $clog2(MAP_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        POOL
    } state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [DW-1:0]    held_q, held_d;
    logic [DW-1:0]    win_q [SIZE-1:0];
    logic [DW-1:0]    win_d [SIZE-1:0];
    logic             last_q, last_d;
    logic             in_ready_q;
    logic             win_en_q;
    logic             win_start_q;
    logic             pool_valid_q;
    logic             frame_done_q;
    logic [DW-1:0]    line_q [MAP_W];
    logic [DW-1:0]    px;
    logic             accept;
    logic             pool_exit;

`ifdef PWB_RELU_EN
    assign px = in_data[DW-1] ? '0 : in_data;
`else
    assign px = in_data;
`endif

    assign accept    = in_valid && in_ready_q;
    assign pool_exit = (state_q == POOL) && pool_done;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        held_d  = held_q;
        win_d   = win_q;
        last_d  = last_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end

                    // Odd rows pair with the row held in the line buffer.
                    if (row_q[0]) begin
                        if (!col_q[0]) begin
                            held_d = px;
                        end else begin
                            win_d[0] = line_q[col_q - COL_W'(1)];
                            win_d[1] = line_q[col_q];
                            win_d[2] = held_q;
                            win_d[3] = px;
                            last_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
                            state_d  = LAUNCH;
                        end
                    end
                end
            end
            LAUNCH: state_d = POOL;
            POOL: begin
                if (pool_done) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            held_q       <= '0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            win_en_q     <= 1'b0;
            win_start_q  <= 1'b0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            held_q       <= held_d;
            last_q       <= last_d;
            win_q        <= win_d;
            in_ready_q   <= (state_d == FILL);
            win_en_q     <= (state_d != FILL);
            win_start_q  <= (state_d == LAUNCH);
            pool_valid_q <= pool_exit;
            frame_done_q <= pool_exit && last_q;
        end
    end

    // NOTE: the line buffer has no reset; every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (accept && !row_q[0]) begin
            line_q[col_q] <= px;
        end
    end

    assign in_ready   = in_ready_q;
    assign win        = win_q;
    assign win_en     = win_en_q;
    assign win_start  = win_start_q;
    assign pool_valid = pool_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Upstream neighbour of the max-pooling stage in the CNN datapath.
- Accepts a raster-order stream of fixed-point activations, one per cycle, and assembles non-overlapping 2x2 pooling windows using a one-row line buffer.
- Presents each window as a 4-entry array, drives the pooler's enable and start strobes, and waits for its done before accepting more pixels.
- Flags when the pooled result is valid and when the frame is complete.

Parameters:
- IL, 8, integer bits of the fixed-point word
- FL, 12, fractional bits of the fixed-point word
- MAP_W, 8, feature-map width in pixels; even, >=2
- MAP_H, 8, feature-map height in pixels; even, >=2
- SIZE, 4, window entries (2x2); fixed, not overridable in practice

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream pixel valid
- in_data  in  IL+FL  pixel, two's-complement fixed point
- in_ready  out  1  block can accept a pixel this cycle
- win  out  IL+FL x SIZE  unpacked array win[SIZE-1:0], window to the pooler
- win_en  out  1  pooler enable
- win_start  out  1  pooler start strobe, one cycle
- pool_done  in  1  pooler done
- pool_valid  out  1  one-cycle pulse; pooler output holds the final max this cycle
- frame_done  out  1  one-cycle pulse with pool_valid of the last window of the frame

Behaviour:
- Reset (async, any time, including mid-window): all outputs 0, state FILL, row/col counters 0, held-pixel register 0.
  - Line buffer contents are don't-care; they are rewritten before use.
  - in_ready is 0 while rst is high, then 1.
- Pixel accept: in_valid && in_ready at a rising edge. col increments and wraps MAP_W-1 -> 0; on wrap, row increments and wraps MAP_H-1 -> 0.
- Even row: pixel written to line[col]; no window is formed.
- Odd row, even col: pixel captured into held register.
- Odd row, odd col: window latched on the accept edge:
  - win[0] = line[col-1], win[1] = line[col]
  - win[2] = held, win[3] = in_data
  - state goes to LAUNCH.
- FSM states:
  - FILL: in_ready=1, win_en=0.
  - LAUNCH: one cycle; win_en=1, win_start=1, in_ready=0; next state POOL.
  - POOL: win_en=1, win_start=0, in_ready=0. When pool_done is sampled high, go to FILL.
- pool_valid is 1 for the single cycle after the POOL exit edge. frame_done is also 1 that cycle if the window was at row MAP_H-1, col MAP_W-1.
- win holds stable from the latch edge until the next window latch.
- Latency, with pixel 4 accepted at edge T:
  - cycle T+1: LAUNCH
  - pooler pointer 0..3 in cycles T+2..T+5; pool_done high in T+5
  - cycle T+6: FILL, pool_valid=1, in_ready=1
- Throughput: a stalled window costs 5 cycles of in_ready=0.
- in_valid low in FILL: no state change; counters hold.
- pool_done outside POOL is ignored.
- Frame wrap: after the last window, counters are 0 and the next frame starts with no idle cycle beyond the window latency.

Optional Feature:
- Macro: PWB_RELU_EN
- Defined: ReLU on ingest. in_data with MSB=1 is replaced by 0 before storing or windowing. All window entries are non-negative, so the pooler's unsigned compare is correct.
- Not defined: in_data is stored unmodified.

Test Plan:
- Reset, MAP_W=4, MAP_H=4, stream pixels 1..16 (integer part, FL zeros) with in_valid held high.
  - Windows in order: {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16}.
  - 4 pool_valid pulses; frame_done only with the 4th.
- Pixel 6 accepted at edge T: win_start high in T+1, in_ready low T+1..T+5, pool_valid and in_ready high in T+6.
- in_valid toggled 1/0 every cycle during FILL: same windows as the first scenario; no pixel dropped or duplicated.
- Assert rst while in POOL of the 2nd window, release, stream 1..16 again:
  - all outputs 0 during reset
  - the first window after release is {1,2,5,6}.
- PWB_RELU_EN defined, pixel 2 = -3.0, others 1..16: first window {1,0,5,6}.
  - Undefined: win[1] = two's-complement -3.0.
- pool_done pulsed high during FILL: no state change, no pool_valid.
